// File: rtl/pixel_collect_interface_if.sv
// Pixel-collect bus: the pixel/index offer side, the memory write port and the
// status flags, bundled so the collector and its environment share one port.
interface pixel_collect_interface_if #(
    parameter int ADDR_W = 19
);
    logic [11:0]       pixel;
    logic [9:0]        row_index;
    logic [9:0]        column_index;
    logic              strobe;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       mem_data;
    logic              mem_ready;
    logic              frame_done;
    logic              busy;
    logic              overflow;
    logic              range_err;

    // Collector side: consumes pixels, drives the memory write port and flags.
    modport slave (
        input  pixel, row_index, column_index, strobe, mem_ready,
        output mem_we, mem_addr, mem_data, frame_done, busy, overflow, range_err
    );

    // Environment side: offers pixels, acts as the memory.
    modport master (
        output pixel, row_index, column_index, strobe, mem_ready,
        input  mem_we, mem_addr, mem_data, frame_done, busy, overflow, range_err
    );
endinterface

// File: rtl/pixel_collect_interface.sv
// Pixel collector: buffers incoming pixels with their linear frame address in a
// small FIFO and drains them to memory, pulsing frame_done after each full frame.
module pixel_collect_interface #(
    parameter int COL_LEN    = 640,
    parameter int ROW_LEN    = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 19
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    pixel_collect_interface_if.slave io_bus
);
    localparam int FRAME_PIX = COL_LEN * ROW_LEN;
    localparam int CNT_W     = $clog2(FRAME_PIX + 1);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);
    localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   ONE_LVL  = (PTR_W + 1)'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [11:0]       r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_fill;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic              r_overflow;
    logic              r_range_err;

    logic [31:0]       w_addr_full;
    logic [ADDR_W-1:0] w_push_addr;
    logic              w_in_range;
    logic              w_empty;
    logic              w_full;
    logic              w_mem_we;
    logic              w_pop;
    logic              w_push;
    logic              w_frame_end;

    assign w_addr_full = 32'(io_bus.row_index) * 32'(COL_LEN) + 32'(io_bus.column_index);
    assign w_push_addr = w_addr_full[ADDR_W-1:0];
    assign w_in_range  = (32'(io_bus.row_index) < 32'(ROW_LEN)) &&
                         (32'(io_bus.column_index) < 32'(COL_LEN));
    assign w_empty     = (r_fill == '0);
    assign w_full      = (r_fill == FULL_LVL);
    assign w_mem_we    = (r_state == ST_WRITE);
    assign w_pop       = w_mem_we && io_bus.mem_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign w_push      = io_bus.strobe && w_in_range && (!w_full || w_pop);
    assign w_frame_end = w_pop && (r_wr_cnt == LAST_PIX);

    // Next-state selection for the IDLE / WRITE / DONE sequencer.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty) w_state_nxt = ST_WRITE;
            ST_WRITE: begin
                if (w_frame_end)
                    w_state_nxt = ST_DONE;
                else if (w_pop && (r_fill == ONE_LVL) && !w_push)
                    w_state_nxt = ST_IDLE;
            end
            ST_DONE:  w_state_nxt = w_empty ? ST_IDLE : ST_WRITE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Control state: sequencer, FIFO pointers, frame counter and sticky flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_wr_cnt    <= '0;
            r_overflow  <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
            if (w_frame_end)
                r_wr_cnt <= '0;
            else if (w_pop)
                r_wr_cnt <= r_wr_cnt + 1'b1;
            if (io_bus.strobe && !w_in_range)
                r_range_err <= 1'b1;
            if (io_bus.strobe && w_in_range && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    // FIFO storage write on accept.
    always_ff @(posedge i_clk) begin
        // NOTE: storage is deliberately not reset; the fill level guards it and the
        // head is only driven onto the bus while in WRITE.
        if (w_push && !i_rst) begin
            r_fifo_addr[r_wr_ptr] <= w_push_addr;
            r_fifo_data[r_wr_ptr] <= io_bus.pixel;
        end
    end

    assign io_bus.mem_we     = w_mem_we;
    assign io_bus.mem_addr   = w_mem_we ? r_fifo_addr[r_rd_ptr] : '0;
    assign io_bus.mem_data   = w_mem_we ? r_fifo_data[r_rd_ptr] : '0;
    assign io_bus.frame_done = (r_state == ST_DONE);
    assign io_bus.busy       = !w_empty || (r_state != ST_IDLE);
    assign io_bus.overflow   = r_overflow;
    assign io_bus.range_err  = r_range_err;
endmodule

// File: doc/pixel_collect_interface.md
PIXEL_COLLECT_INTERFACE -- requirements
Module: pixel_collect_interface

Interface
REQ-001 The block SHALL have parameter COL_LEN, default 640, meaning pixels per image row.
REQ-002 The block SHALL have parameter ROW_LEN, default 480, meaning rows per frame.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning entries in the input buffer (power of two, minimum 2).
REQ-004 The block SHALL have parameter ADDR_W, default 19, meaning memory address width (at least ceil(log2(COL_LEN*ROW_LEN))).
REQ-005 Clock  input  1  single clock; all logic on its rising edge.
REQ-006 Reset  input  1  reset, synchronous and active-high.
REQ-007 pixel  input  12  pixel value from the transfer side.
REQ-008 row_index  input  10  row of the offered pixel.
REQ-009 column_index  input  10  column of the offered pixel.
REQ-010 strobe  input  1  pixel/index valid; sampled on the rising edge.
REQ-011 mem_we  output  1  memory write request.
REQ-012 mem_addr  output  ADDR_W  write address.
REQ-013 mem_data  output  12  write data.
REQ-014 mem_ready  input  1  memory accepts the write in this cycle.
REQ-015 frame_done  output  1  one-cycle pulse when a full frame has been written.
REQ-016 busy  output  1  high while the FIFO is non-empty or the state is not IDLE.
REQ-017 overflow  output  1  sticky: a pixel was dropped because the FIFO was full.
REQ-018 range_err  output  1  sticky: a pixel was dropped because its index was out of range.

Function
REQ-019 Accept: on a rising edge with strobe=1, valid indices (row_index<ROW_LEN, column_index<COL_LEN) and FIFO not full, the block SHALL push {row_index*COL_LEN+column_index, pixel} into the FIFO. The address is computed at push, truncated to ADDR_W.
REQ-020 Push while full SHALL be accepted only if a pop occurs on the same edge; otherwise the pixel SHALL be dropped and overflow set.
REQ-021 An out-of-range index SHALL drop the pixel and set range_err, with no FIFO change. If both drop conditions hold, only range_err SHALL be set.
REQ-022 FSM states SHALL be IDLE, WRITE and DONE.
REQ-023 IDLE -> WRITE on the edge after which the FIFO is non-empty.
REQ-024 WRITE: mem_we=1, mem_addr and mem_data = FIFO head (combinational from head). A pop SHALL occur on an edge with mem_we=1 and mem_ready=1.
REQ-025 While mem_ready=0, mem_addr and mem_data SHALL be held stable.
REQ-026 WRITE -> IDLE when a pop empties the FIFO and the written count has not reached the frame size.
REQ-027 A written-pixel counter (ceil(log2(COL_LEN*ROW_LEN+1)) bits) SHALL increment on each pop.
REQ-028 When a pop makes the count equal COL_LEN*ROW_LEN, the counter SHALL clear to 0 and the FSM SHALL go to DONE.
REQ-029 DONE: frame_done=1 and mem_we=0 for exactly one cycle, then -> WRITE if the FIFO is non-empty, else -> IDLE. Pushes remain allowed in DONE.
REQ-030 Latency: a pixel accepted at edge N into an empty FIFO with state IDLE SHALL appear with mem_we=1 in the cycle after edge N+1 (IDLE->WRITE transition at edge N+1).
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Order SHALL be strictly first-in first-out.
REQ-032 overflow and range_err SHALL clear only on Reset.

Reset
REQ-033 With Reset=1 at a rising edge, the block SHALL set: state IDLE, FIFO empty, counter 0, mem_we=0, frame_done=0, busy=0, overflow=0, range_err=0. mem_addr and mem_data SHALL both be 0.
REQ-034 Reset mid-write SHALL discard all buffered pixels, and no further mem_we SHALL occur until a new pixel is accepted. Strobe SHALL be ignored on any edge where Reset=1.

Verification
REQ-035 Single pixel: row 2, col 5, pixel 0xABC, mem_ready=1 -> exactly one write with mem_addr=1285, mem_data=0xABC, with mem_we high in the cycle after the edge following acceptance.
REQ-036 Backpressure: 6 consecutive strobes, mem_ready=0 throughout (FIFO_DEPTH=4) -> 4 entries held and overflow=1; after mem_ready=1, 4 writes occur in order with no gaps.
REQ-037 Range: column_index=640 or row_index=480 -> no write and range_err=1; a following valid pixel is still written.
REQ-038 Frame: COL_LEN=4, ROW_LEN=2, 8 pixels, mem_ready=1 -> addresses 0..7, one frame_done pulse after the 8th write, counter back to 0; a 9th pixel is written to its own address.
REQ-039 Reset with 3 entries buffered and mem_ready=0 -> next cycle mem_we=0, busy=0, flags 0; then mem_ready=1 for 5 cycles -> no writes.
